ram_sp_param: RTL
=================

Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM for the 16-bit CPU; next generation of the fixed 16x16 block RAM wrapper.
- Adds configurable width, depth and read latency, plus read-first/write-first selection.
- Adds a hardware clear sequencer with busy indication and a read-valid strobe.
- Sits between the CPU datapath/control unit and data storage; inferred RAM, no vendor IP.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- RD_MODE, 0, collision mode on write access: 0 = read-first (old word returned), 1 = write-first (new word returned).
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sequence.

Ports:
- sys_clk  input  1  clock, all logic on rising edge.
- sys_rst_n  input  1  synchronous reset, active-high (port name kept per codebase; asserted = 1).
- ram_en  input  1  access request; accepted only when ram_busy = 0.
- ram_wea  input  1  1 = write, 0 = read; sampled with ram_en.
- ram_addr  input  ADDR_W  word address.
- ram_wr_data  input  DATA_W  write data.
- ram_clr  input  1  single-cycle request to re-initialise the whole array.
- ram_par_inj  input  1  parity-error injection on write (used only with the optional feature).
- ram_rd_data  output  DATA_W  read data.
- ram_rd_valid  output  1  one-cycle strobe: ram_rd_data holds the result of an accepted access.
- ram_busy  output  1  clear sequence in progress; accesses are refused.
- ram_par_err  output  1  parity mismatch on the returned word, qualified by ram_rd_valid.

Behaviour:
- Reset values: ram_rd_data = 0, ram_rd_valid = 0, ram_par_err = 0, ram_busy = 1. Latency pipeline is flushed; FSM enters CLEAR with clr_addr = 0.
- FSM states:
  - CLEAR: each cycle writes INIT_VAL to clr_addr, then increments clr_addr. At clr_addr = DEPTH-1 the FSM writes and moves to READY. The clear sequence takes exactly DEPTH cycles.
  - READY: ram_busy = 0. ram_clr = 1 moves to CLEAR next cycle with clr_addr = 0 and ram_busy = 1.
- In CLEAR: ram_en and ram_clr are ignored, with no queuing.
- Accepted access: ram_en = 1 and ram_busy = 0 in the same cycle.
  - Write stores ram_wr_data at ram_addr at that edge.
  - Every accepted access (read or write) produces ram_rd_valid = 1 exactly RD_LAT cycles later.
  - Returned ram_rd_data is the word at ram_addr. On a write it is the old word for RD_MODE = 0 and ram_wr_data for RD_MODE = 1.
- Back-to-back accepted accesses every cycle give back-to-back valid strobes with no bubbles.
- ram_clr and ram_en asserted together in READY: the access is accepted and completes normally, and the clear starts next cycle. Accesses already in the latency pipeline still deliver their valid strobe during CLEAR.
- ram_rd_data holds its last value when ram_rd_valid = 0.
- Reset asserted mid-operation (including mid-CLEAR) drops in-flight strobes, returns outputs to reset values and restarts CLEAR at address 0.
- Address width exactly covers DEPTH, so no out-of-range handling is needed.

Optional Feature:
- Macro: RAM_SP_PARAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed from ram_wr_data (or INIT_VAL during clear).
  - When ram_par_inj = 1 on an accepted write, the stored parity bit is inverted.
  - On each returned word the parity is recomputed; ram_par_err = 1 together with ram_rd_valid on mismatch, otherwise 0.
  - Write-first returns compare against the injected stored bit.
- Undefined: no parity storage; ram_par_err tied 0; ram_par_inj ignored. Ports remain present in both builds.

Test Plan:
- Reset with defaults, then release: ram_busy = 1 for exactly 16 cycles, then 0. Reads of addresses 0..15 return 0x0000 with ram_rd_valid one cycle after each request.
- RD_LAT = 2: write 0xA5A5 @3, then read @3 next cycle. Valid goes high 2 cycles after the read with data 0xA5A5. The write access also strobes valid 2 cycles after it.
- Collision on 0x1234 @5 holding 0xBEEF: RD_MODE = 0 returns 0xBEEF on the write's strobe; RD_MODE = 1 returns 0x1234.
- Write 0xFFFF to all addresses, pulse ram_clr together with a read @7. The read returns 0xFFFF, then busy holds 16 cycles. ram_en pulses during busy produce no strobe; all addresses then read INIT_VAL.
- Assert reset at cycle 5 of CLEAR with a read in flight: no strobe appears, outputs are 0, and busy lasts a full 16 cycles from release.
- With RAM_SP_PARAM_PARITY_EN defined: write 0x0001 @2 with ram_par_inj = 1, then read @2 → ram_par_err = 1 with valid. Rewrite @2 without injection, then read → ram_par_err = 0.

Source files
------------

// File: rtl/ram_sp_param.sv
// Single-port synchronous RAM with a configurable read latency, a collision mode and a clear sequencer.
// Optional stored parity per word: define RAM_SP_PARAM_PARITY_EN.
module ram_sp_param #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter int                RD_LAT   = 1,
    parameter int                RD_MODE  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              ram_en,
    input  logic              ram_wea,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wr_data,
    input  logic              ram_clr,
    input  logic              ram_par_inj,
    output logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_rd_valid,
    output logic              ram_busy,
    output logic              ram_par_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_acc;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ret_data;
    logic              w_ret_perr;

    logic              w_s_vld;
    logic [DATA_W-1:0] w_s_data;
    logic              w_s_perr;

    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_par_err;

    // Reset is active-high despite the port name.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        unique case (r_state)
            ST_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt    = ST_READY;
                    w_clr_addr_nxt = '0;
                end
            end
            ST_READY: begin
                if (ram_clr) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
        endcase
    end

    assign ram_busy = (r_state == ST_CLEAR);
    assign w_acc    = ram_en & ~ram_busy;

    // The clear sequencer owns the write port while busy.
    assign w_we    = ram_busy | (w_acc & ram_wea);
    assign w_waddr = ram_busy ? r_clr_addr : ram_addr;
    assign w_wdata = ram_busy ? INIT_VAL : ram_wr_data;

    always_ff @(posedge sys_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign w_ret_data = ((RD_MODE == 1) && ram_wea) ? ram_wr_data
                                                    : r_mem[ram_addr];

`ifdef RAM_SP_PARAM_PARITY_EN
    logic r_par [DEPTH];
    logic w_wpar;
    logic w_ret_par;

    assign w_wpar = ram_busy ? (^INIT_VAL) : ((^ram_wr_data) ^ ram_par_inj);

    always_ff @(posedge sys_clk) begin
        if (w_we) begin
            r_par[w_waddr] <= w_wpar;
        end
    end

    assign w_ret_par  = ((RD_MODE == 1) && ram_wea) ? w_wpar : r_par[ram_addr];
    assign w_ret_perr = (^w_ret_data) ^ w_ret_par;
`else
    logic w_unused_par;

    assign w_unused_par = ram_par_inj;
    assign w_ret_perr   = 1'b0;
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_p1_vld;
            logic [DATA_W-1:0] r_p1_data;
            logic              r_p1_perr;

            always_ff @(posedge sys_clk) begin
                if (sys_rst_n) begin
                    r_p1_vld  <= 1'b0;
                    r_p1_data <= '0;
                    r_p1_perr <= 1'b0;
                end else begin
                    r_p1_vld  <= w_acc;
                    r_p1_data <= w_ret_data;
                    r_p1_perr <= w_ret_perr;
                end
            end

            assign w_s_vld  = r_p1_vld;
            assign w_s_data = r_p1_data;
            assign w_s_perr = r_p1_perr;
        end else begin : g_lat1
            assign w_s_vld  = w_acc;
            assign w_s_data = w_ret_data;
            assign w_s_perr = w_ret_perr;
        end
    endgenerate

    // Read data only moves on a strobe so it holds between results.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_rd_valid <= w_s_vld;
            r_par_err  <= w_s_vld & w_s_perr;
            if (w_s_vld) begin
                r_rd_data <= w_s_data;
            end
        end
    end

    assign ram_rd_data  = r_rd_data;
    assign ram_rd_valid = r_rd_valid;
    assign ram_par_err  = r_par_err;

endmodule
